// File: rtl/viterbi_stream_decoder.sv
// Streaming rate-1/N soft-decision Viterbi decoder with register-exchange survivors.
// Decisions are emitted TB symbols late while running; i_last drains the remaining survivor bits.
module viterbi_stream_decoder #(
  parameter int             K    = 3,
  parameter int             N    = 2,
  parameter int             Q    = 3,
  parameter int             TB   = 15,
  parameter logic [N*K-1:0] POLY = 6'b111_101,
  parameter bit             TERM = 1'b0,
  parameter int             PMW  = 10
) (
  input  logic           sys_clk,
  input  logic           rst,
  input  logic [N*Q-1:0] i_sym,
  input  logic           i_valid,
  input  logic           i_last,
  output logic           i_ready,
  output logic           o_bit,
  output logic           o_valid,
  output logic           o_last,
  input  logic           o_ready
);
  // state | meaning
  // RUN   | accept symbols; emit the oldest decision once the survivors are full
  // FLUSH | latch drain state and pointer, then drain survivor bits oldest-first
  typedef enum logic {RUN, FLUSH} state_t;

  localparam int S  = K - 1;
  localparam int NS = 1 << S;
  localparam int FW = $clog2(TB + 1);
  localparam int PW = $clog2(TB);
  localparam logic [Q-1:0]   QMAX     = '1;
  localparam logic [PMW-1:0] PM_INIT  = PMW'(K * N * ((1 << Q) - 1));
  localparam logic [FW-1:0]  FILL_MAX = FW'(TB);

  // Metrics wrap, so ordering is the sign of the modular difference.
  function automatic logic better(input logic [PMW-1:0] a, input logic [PMW-1:0] b);
    logic [PMW-1:0] d;
    d = a - b;
    return d[PMW-1];
  endfunction

  state_t         state_q, state_d;
  logic [PMW-1:0] pm      [NS];
  logic [PMW-1:0] pm_nxt  [NS];
  logic [TB-1:0]  sur     [NS];
  logic [TB-1:0]  sur_nxt [NS];
  logic [PMW-1:0] bm      [2*NS];
  logic [PMW-1:0] acc;
  logic [PMW-1:0] best_pm;
  logic [S-1:0]   best, sel;
  logic [FW-1:0]  fill;
  logic [PW-1:0]  ptr;
  logic           lat_pend, accept, flush_load, out_free;

  // Branch metric indexed by the full encoder register {u, pred}.
  always_comb begin
    acc = '0;
    for (int r = 0; r < 2 * NS; r++) begin
      acc = '0;
      for (int j = 0; j < N; j++) begin
        if (^(POLY[(N - j) * K - 1 -: K] & K'(r)))
          acc = acc + PMW'(QMAX - i_sym[(N - j) * Q - 1 -: Q]);
        else
          acc = acc + PMW'(i_sym[(N - j) * Q - 1 -: Q]);
      end
      bm[r] = acc;
    end
  end

  for (genvar t = 0; t < NS; t++) begin : g_acs
    localparam logic [S-1:0] TV = S'(t);
    localparam logic [S-1:0] P0 = {TV[S-2:0], 1'b0};
    localparam logic [S-1:0] P1 = {TV[S-2:0], 1'b1};
    logic [PMW-1:0] c0, c1;
    logic           pick1;
    assign c0         = pm[P0] + bm[{TV, 1'b0}];
    assign c1         = pm[P1] + bm[{TV, 1'b1}];
    assign pick1      = better(c1, c0);
    assign pm_nxt[t]  = pick1 ? c1 : c0;
    assign sur_nxt[t] = {pick1 ? sur[P1][TB-2:0] : sur[P0][TB-2:0], TV[S-1]};
  end

  always_comb begin
    best    = '0;
    best_pm = pm[0];
    for (int s = 1; s < NS; s++) begin
      if (better(pm[s], best_pm)) begin
        best    = S'(s);
        best_pm = pm[s];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    out_free   = !o_valid || o_ready;
    i_ready    = 1'b0;
    accept     = 1'b0;
    flush_load = 1'b0;
    case (state_q)
      RUN: begin
        i_ready = !rst && out_free;
        accept  = i_valid && i_ready;
        if (accept && i_last) state_d = FLUSH;
      end
      FLUSH: begin
        flush_load = !lat_pend && out_free;
        if (flush_load && ptr == '0) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      o_bit    <= 1'b0;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
      fill     <= '0;
      sel      <= '0;
      ptr      <= '0;
      lat_pend <= 1'b0;
      for (int s = 0; s < NS; s++) begin
        pm[s]  <= (s == 0) ? '0 : PM_INIT;
        sur[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (o_valid && o_ready) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
      if (accept) begin
        if (fill == FILL_MAX) begin
          o_bit   <= sur[best][TB-1];
          o_valid <= 1'b1;
          o_last  <= 1'b0;
        end else begin
          fill <= fill + FW'(1);
        end
        pm       <= pm_nxt;
        sur      <= sur_nxt;
        lat_pend <= i_last;
      end
      // sel must see the metrics of the last symbol, hence one edge after its accept.
      if (lat_pend) begin
        sel      <= TERM ? '0 : best;
        ptr      <= PW'(fill - FW'(1));
        lat_pend <= 1'b0;
      end
      if (flush_load) begin
        o_bit   <= sur[sel][ptr];
        o_valid <= 1'b1;
        o_last  <= (ptr == '0);
        if (ptr == '0) begin
          fill <= '0;
          for (int s = 0; s < NS; s++) begin
            pm[s]  <= (s == 0) ? '0 : PM_INIT;
            sur[s] <= '0;
          end
        end else begin
          ptr <= ptr - PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_viterbi_stream_decoder.sv
// Bench for viterbi_stream_decoder at K=3, N=2, Q=3, TB=15, tail-terminated frames.
// Frames come from a small convolutional encoder; decoded bits must equal the encoded data.
module tb_viterbi_stream_decoder;
  localparam int TB = 15;

  logic       sys_clk = 1'b0;
  logic       rst, i_valid, i_last, i_ready, o_bit, o_valid, o_last, o_ready;
  logic [5:0] i_sym;
  logic [1:0] enc_s;
  logic [5:0] sym_t;
  int         n_pass  = 0;
  int         n_total = 0;

  // err: 0 clean, 1 invert channel 0 every 10th symbol, 2 erase every 5th channel to 3/4
  typedef struct {
    logic [63:0] data;
    int          n;
    int          err;
    bit          rnd;
    bit          chk_early;
  } vec_t;
  vec_t tbl [9];

  viterbi_stream_decoder #(
    .K(3), .N(2), .Q(3), .TB(TB), .POLY(6'b111_101), .TERM(1'b1), .PMW(10)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .i_sym   (i_sym),
    .i_valid (i_valid),
    .i_last  (i_last),
    .i_ready (i_ready),
    .o_bit   (o_bit),
    .o_valid (o_valid),
    .o_last  (o_last),
    .o_ready (o_ready)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no summary, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  task automatic enc(input logic u, output logic [5:0] sym);
    logic [2:0] r;
    r     = {u, enc_s};
    enc_s = {u, enc_s[1]};
    sym   = {{3{^(r & 3'b111)}}, {3{^(r & 3'b101)}}};
  endtask

  task automatic run_frame(input int r);
    logic [5:0] syms [64];
    int         si, oc, cyc, c;
    bit         done, last_acc, early;
    enc_s = 2'b00;
    for (int i = 0; i < tbl[r].n; i++) begin
      enc(tbl[r].data[i], syms[i]);
      if (tbl[r].err == 1 && i % 10 == 9) syms[i][5:3] = ~syms[i][5:3];
      if (tbl[r].err == 2) begin
        for (int j = 0; j < 2; j++) begin
          c = 2 * i + j;
          if (c % 5 == 2) begin
            if (j == 0) syms[i][5:3] = (c % 2 == 1) ? 3'd4 : 3'd3;
            else        syms[i][2:0] = (c % 2 == 1) ? 3'd4 : 3'd3;
          end
        end
      end
    end
    si = 0; oc = 0; cyc = 0; done = 0; last_acc = 0; early = 0;
    while (!done && cyc < 1000) begin
      @(negedge sys_clk);
      i_valid = (si < tbl[r].n);
      i_sym   = i_valid ? syms[si] : 6'd0;
      i_last  = (si == tbl[r].n - 1);
      o_ready = tbl[r].rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (o_valid && !o_ready) chk($sformatf("row%0d_bp_iready", r), i_ready, 0);
      if (o_valid && !last_acc) early = 1;
      if (o_valid && o_ready) begin
        if (oc < tbl[r].n) begin
          chk($sformatf("row%0d_bit%0d", r, oc), o_bit, tbl[r].data[oc]);
          chk($sformatf("row%0d_last%0d", r, oc), o_last, (oc == tbl[r].n - 1));
        end else begin
          chk($sformatf("row%0d_extra_bit", r), oc, tbl[r].n - 1);
        end
        if (o_last) done = 1;
        oc++;
      end
      if (i_valid && i_ready) begin
        if (i_last) last_acc = 1;
        si++;
      end
      cyc++;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    chk($sformatf("row%0d_done", r), done, 1);
    chk($sformatf("row%0d_count", r), oc, tbl[r].n);
    if (tbl[r].chk_early) chk($sformatf("row%0d_early_out", r), early, 0);
  endtask

  initial begin
    tbl[0] = '{64'hB5E31A47, 34, 0, 1'b0, 1'b0};
    tbl[1] = '{64'hB5E31A47, 34, 1, 1'b0, 1'b0};
    tbl[2] = '{64'hB5E31A47, 34, 2, 1'b0, 1'b0};
    tbl[3] = '{64'hB5E31A47, 34, 0, 1'b1, 1'b0};
    tbl[4] = '{64'h3,         5, 0, 1'b0, 1'b1};
    tbl[5] = '{64'h0,         1, 0, 1'b0, 1'b1};
    tbl[6] = '{64'h0A5C3,    20, 1, 1'b1, 1'b0};
    tbl[7] = '{64'h3B5A,     16, 0, 1'b0, 1'b0};
    tbl[8] = '{64'h1DA7,     15, 0, 1'b0, 1'b1};

    rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_sym = 6'd0; o_ready = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1;
    chk("rst_iready", i_ready, 0);
    chk("rst_ovalid", o_valid, 0);
    chk("rst_olast", o_last, 0);
    chk("rst_obit", o_bit, 0);
    @(negedge sys_clk);
    rst = 1'b0;
    #1 chk("rel_iready", i_ready, 1);

    for (int r = 0; r < 9; r++) run_frame(r);

    // Flush latency and backpressure hold on a 3-symbol frame 1,0,0.
    enc_s = 2'b00;
    o_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      enc((i == 0), sym_t);
      i_sym = sym_t; i_valid = 1'b1; i_last = (i == 2);
      #1 chk("lat_iready", i_ready, 1);
    end
    @(negedge sys_clk);
    i_valid = 1'b0; i_last = 1'b0; o_ready = 1'b0;
    #1 chk("lat_edge0_valid", o_valid, 0);
    @(negedge sys_clk);
    #1 chk("lat_edge1_valid", o_valid, 0);
    @(negedge sys_clk);
    #1;
    chk("lat_edge2_valid", o_valid, 1);
    chk("lat_edge2_bit", o_bit, 1);
    chk("lat_edge2_last", o_last, 0);
    for (int h = 0; h < 3; h++) begin
      @(negedge sys_clk);
      #1;
      chk("hold_valid", o_valid, 1);
      chk("hold_bit", o_bit, 1);
      chk("hold_iready", i_ready, 0);
    end
    o_ready = 1'b1;
    @(negedge sys_clk);
    #1;
    chk("drain1_valid", o_valid, 1);
    chk("drain1_bit", o_bit, 0);
    chk("drain1_last", o_last, 0);
    @(negedge sys_clk);
    #1;
    chk("drain2_valid", o_valid, 1);
    chk("drain2_bit", o_bit, 0);
    chk("drain2_last", o_last, 1);
    @(negedge sys_clk);
    #1 chk("drain_done_valid", o_valid, 0);

    // Reset while draining, then a clean frame straight after.
    enc_s = 2'b00;
    for (int i = 0; i < 34; i++) begin
      @(negedge sys_clk);
      enc(tbl[0].data[i], sym_t);
      i_sym = sym_t; i_valid = 1'b1; i_last = (i == 33);
      #1 chk("rf_iready", i_ready, 1);
    end
    @(negedge sys_clk);
    i_valid = 1'b0; i_last = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    #1;
    chk("rf_flush_valid", o_valid, 1);
    chk("rf_flush_bit", o_bit, tbl[0].data[19]);
    rst = 1'b1;
    #1;
    chk("rf_rst_valid", o_valid, 0);
    chk("rf_rst_last", o_last, 0);
    chk("rf_rst_iready", i_ready, 0);
    @(negedge sys_clk);
    rst = 1'b0;
    run_frame(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/viterbi_stream_decoder.md
# viterbi_stream_decoder

Streaming, parametrised Viterbi decoder core for rate-1/N convolutional codes with soft-decision inputs and register-exchange survivor storage. It is the next-generation replacement for the fixed-configuration, enable-sequenced decoder chain. It accepts one N-channel soft symbol per handshake and emits decoded bits through a valid/ready interface. On a frame-end marker it drains the survivor paths, with optional tail-terminated selection.

## Interface
- K, 3: constraint length, legal 3..7; 2^(K-1) states.
- N, 2: code outputs per input bit, legal 2..4.
- Q, 3: soft bits per channel, legal 1..8 (Q=1 is hard decision).
- TB, 15: survivor depth in bits, legal K..64.
- POLY, 6'b111_101: N*K packed generators; polynomial j occupies bits [(N-j)*K-1 -: K], so j=0 is in the MSBs. Bit K-1 of each polynomial taps the newest input bit.
- TERM, 0: 1 = flush from state 0 (tail-terminated frames); 0 = flush from the best-metric state.
- PMW, 10: path-metric width; must be >= clog2(K*N*(2^Q-1))+3.
- sys_clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_sym  in  N*Q  soft symbol; channel j is at [(N-j)*Q-1 -: Q]. 0 = confident '0', 2^Q-1 = confident '1'.
- i_valid  in  1  i_sym/i_last valid.
- i_last  in  1  marks the final symbol of a frame.
- i_ready  out  1  symbol accepted when i_valid && i_ready.
- o_bit  out  1  decoded bit.
- o_valid  out  1  o_bit valid.
- o_last  out  1  final decoded bit of the frame.
- o_ready  in  1  output consumed when o_valid && o_ready.

## Operation
- State s is K-1 bits, holding the most recent inputs. The encoder register is {u,s}. Next state is {u, s[K-2:1]}. Output j = ^(POLY_j & {u,s}).
- Branch metric: per channel, the cost is r if the expected bit is 0, and (2^Q-1)-r if it is 1. BM is the sum over N channels. Lower cost is better.
- ACS, per new state t with u=t[K-2]: predecessors are {t[K-3:0],0} and {t[K-3:0],1}. Candidate metric = PM[pred]+BM, computed modulo 2^PMW.
  - a is better than b iff (a-b) is negative when read as signed PMW.
  - On a tie, predecessor with b=0 wins.
- Survivor update: SUR[t] <= {SUR[pred][TB-2:0], u}. Bit TB-1 holds the oldest decision.
- Best state: the lowest PM under the modular compare; on a tie, the lowest index wins.
- Frame start, also applied at reset: PM[0]=0, all other PM = K*N*(2^Q-1). SUR=0, fill=0.
- FSM, two states: RUN and FLUSH.
- RUN:
  - i_ready = !rst && (!o_valid || o_ready).
  - On accept, read the pre-update metrics. If fill==TB, load o_bit <= SUR[best][TB-1] and set o_valid=1.
  - In the same cycle, ACS and survivors update, and fill <= min(fill+1, TB).
  - If i_last is set, go to FLUSH. Latch sel = TERM ? 0 : best, computed from the post-update metrics, on the following edge. Set ptr = new fill - 1.
- FLUSH:
  - i_ready=0.
  - Whenever the output register is free (!o_valid || o_ready), load o_bit <= SUR[sel][ptr] and decrement ptr.
  - When ptr==0, also set o_last=1, reinitialise the metrics and go to RUN.
- Output accounting: a frame of n symbols yields exactly n bits, in input order. RUN emits max(0, n-TB) of them and FLUSH emits min(n, TB).
- The output register is cleared (o_valid=0, o_last=0) on a consume with no new load.

## Timing
- Reset values: o_bit=0, o_valid=0, o_last=0, FSM=RUN. i_ready=0 while rst is high and 1 on the first cycle after release.
- Latency: a RUN-emitted bit is valid on the cycle after the accepting edge. Each decision emerges TB symbols after its input symbol.
- The first FLUSH bit is valid 2 cycles after the last-symbol accept edge. This includes the cycle in which sel and ptr are latched.
- Throughput: one symbol per cycle while o_ready=1. Flush drains one bit per cycle.
- Backpressure: when o_valid && !o_ready, i_ready=0, and all of o_bit, o_valid, o_last, PM, SUR and FSM hold.
- A simultaneous consume and accept in the same cycle is legal and produces no bubble.
- i_last on a frame with n=1 gives ptr=0: the single bit is emitted with o_last=1.
- A reset asserted mid-frame or in FLUSH clears everything immediately. No partial frame survives it.

## Test plan
- Defaults with TERM=1: encode 0xB5E31A47 LSB-first plus 2 zero tail bits, map hard bits to 0/7, last on symbol 34 -> 34 o_valid bits equal to the input, o_last only on bit 34.
- Same stream with one channel inverted (7->0) on every 10th symbol -> output identical to the error-free run.
- Erasures: set 20% of the channels to 3 or 4 -> zero bit errors. Q=1 hard decision with 1 error per 12 symbols -> zero errors.
- o_ready toggled pseudo-randomly at 50% -> same 34-bit sequence, no drops or duplicates. i_ready=0 whenever o_valid&&!o_ready.
- 5-symbol frame (n<TB) -> no output before i_last, then 5 bits from FLUSH with o_last on the 5th. The next frame decodes correctly straight after.
- K=7, N=3, POLY octal 133/171/165, TB=40: 200 random bits plus 6 tail bits -> exact match. Then rst pulse during FLUSH -> o_valid=0 in the same cycle, and the following frame decodes correctly.
